deserializer_sipo: RTL

DESERIALIZER_SIPO -- requirements
Module: deserializer_sipo

---
 rtl/deserializer_sipo.sv | 98 +++++++++
 1 files changed

// File: rtl/deserializer_sipo.sv
// rtl/deserializer_sipo.sv - serial-in parallel-out deserializer with framing and a single-word output holding register
module deserializer_sipo #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  srl_in,
  input  logic                  bit_valid,
  input  logic                  frame_start,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  busy,
  output logic                  overrun,
  output logic                  frame_err
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                state, state_nx;
  logic [CW-1:0]         cnt, cnt_nx;
  logic [DATA_WIDTH-1:0] sreg, sreg_nx;
  logic                  word_done;
  logic                  frame_err_nx;

  // Next-state logic: frame_start always restarts assembly at bit 0; a restart
  // while a word is in progress discards it and flags a truncated word.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    sreg_nx      = sreg;
    word_done    = 1'b0;
    frame_err_nx = 1'b0;
    if (bit_valid) begin
      if (frame_start) begin
        frame_err_nx = (state == SHIFT);
        sreg_nx      = '0;
        sreg_nx[0]   = srl_in;
        cnt_nx       = CW'(1);
        state_nx     = SHIFT;
      end else if (state == SHIFT) begin
        sreg_nx[cnt] = srl_in;
        if (cnt == LAST_IDX) begin
          word_done = 1'b1;
          cnt_nx    = '0;
          state_nx  = IDLE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
    end
  end

  // Assembly state register; idle strobes without frame_start leave it untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      sreg  <= sreg_nx;
    end
  end

  // Output holding register: a completed word loads only if the slot is free or
  // being drained this cycle; otherwise it is dropped and overrun sticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= frame_err_nx;
      if (word_done) begin
        if (!data_valid || data_ready) begin
          data_out   <= sreg_nx;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

  assign busy = (state == SHIFT);

endmodule
